// File: rtl/fdu_pkg.sv
// Shared types and constants for the fetch/decode unit: FSM states,
// condition-code encodings and instruction field bit positions.
package fdu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } fdu_state_e;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_HI = 4'd9;
  localparam logic [3:0] COND_LS = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GT = 4'd13;
  localparam logic [3:0] COND_LE = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int unsigned COND_MSB = 31;
  localparam int unsigned COND_LSB = 28;
  localparam int unsigned OPC_MSB  = 27;
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned BIT_S    = 23;
  localparam int unsigned RD_MSB   = 22;
  localparam int unsigned RD_LSB   = 19;
  localparam int unsigned RS2_MSB  = 18;
  localparam int unsigned RS2_LSB  = 15;
  localparam int unsigned RS1_MSB  = 14;
  localparam int unsigned RS1_LSB  = 11;
  localparam int unsigned IV_MSB   = 10;
  localparam int unsigned IV_LSB   = 6;
  localparam int unsigned OFF_MSB  = 18;
  localparam int unsigned OFF_W    = 19;

endpackage

// File: rtl/fdu_cond_eval.sv
// Combinational condition-code evaluator; flags are {N,Z,C,V}.
module fdu_cond_eval
  import fdu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = flags;
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction fetch/decode FSM with PC-relative branch and halt.
// Conditional execution is enabled by defining FDU_COND_EXEC_EN.
module fetch_decode_unit
  import fdu_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter logic [3:0]  BR_OPCODE   = 4'hA,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [3:0]        flags,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [3:0]        cond,
  output logic [3:0]        opcode,
  output logic              s,
  output logic [3:0]        rd,
  output logic [3:0]        rs2,
  output logic [3:0]        rs1,
  output logic [4:0]        iv,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  fdu_state_e             state, state_nx;
  logic [31:0]            ir;
  logic                   ce_pass;
  logic                   cond_ok;
  logic [PC_W+OFF_W-1:0]  off_ext;

  // The condition is judged on the incoming word in the cycle it is latched.
  fdu_cond_eval u_cond_eval (
    .cond  (mem_rdata[COND_MSB:COND_LSB]),
    .flags (flags),
    .pass  (ce_pass)
  );

`ifdef FDU_COND_EXEC_EN
  assign cond_ok = ce_pass;
`else
  logic unused_ce_pass;
  assign unused_ce_pass = ce_pass;
  assign cond_ok        = 1'b1;
`endif

  assign off_ext  = {{PC_W{ir[OFF_MSB]}}, ir[OFF_MSB:0]};
  assign mem_rw   = 1'b0;
  assign mem_addr = ADDR_W'(pc);

  assign cond   = ir[COND_MSB:COND_LSB];
  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign s      = ir[BIT_S];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs2    = ir[RS2_MSB:RS2_LSB];
  assign rs1    = ir[RS1_MSB:RS1_LSB];
  assign iv     = ir[IV_MSB:IV_LSB];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    dec_valid = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: begin
        mem_en   = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          if (!cond_ok)                                        state_nx = S_FETCH;
          else if (mem_rdata[OPC_MSB:OPC_LSB] == HALT_OPCODE) state_nx = S_HALT;
          else                                                 state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dec_valid = 1'b1;
        if (dec_ready) state_nx = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc <= '0;
      ir <= '0;
    end else if (state == S_WAIT && mem_ready) begin
      ir <= mem_rdata;
      if (!cond_ok) pc <= pc + PC_W'(1);
    end else if (state == S_ISSUE && dec_ready) begin
      if (ir[OPC_MSB:OPC_LSB] == BR_OPCODE) pc <= pc + off_ext[PC_W-1:0];
      else                                  pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: directed scenarios plus a
// randomized program run against an instruction-level reference model.
module tb_fetch_decode_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        mem_en, mem_rw;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [3:0]  flags;
  logic        dec_valid, dec_ready;
  logic [3:0]  cond, opcode, rd, rs2, rs1;
  logic        s;
  logic [4:0]  iv;
  logic [7:0]  pc;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [256];
  logic [7:0]  m_pc;

  always #5 Clk = ~Clk;

  fetch_decode_unit #(
    .PC_W        (8),
    .ADDR_W      (16),
    .BR_OPCODE   (4'hA),
    .HALT_OPCODE (4'hF)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .flags     (flags),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .cond      (cond),
    .opcode    (opcode),
    .s         (s),
    .rd        (rd),
    .rs2       (rs2),
    .rs1       (rs1),
    .iv        (iv),
    .pc        (pc),
    .halted    (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural rule: does condition c hold for flags {N,Z,C,V}?
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
`ifdef FDU_COND_EXEC_EN
    bit n, z, cf, v;
    bit tbl [16];
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    tbl = '{1'b1, z, !z, cf, !cf, n, !n, v, !v, cf && !z, !cf || z,
            n == v, n != v, !z && (n == v), z || (n != v), 1'b0};
    return tbl[c];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] branch_target(input logic [7:0] p, input logic [31:0] w);
    int off;
    off = int'(w[18:0]);
    if (w[18]) off = off - (1 << 19);
    return 8'(int'(p) + off);
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_dec_valid", dec_valid, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_fields", {cond, opcode, s, rd, rs2, rs1, iv}, 0);
  endtask

  // Pulse reset off-edge, verify idle behaviour, then start from PC 0.
  task automatic do_reset();
    #2 Reset = 1'b0;
    #1 check_reset_outputs();
    start = 1'b0; mem_ready = 1'b0; dec_ready = 1'b0;
    @(negedge Clk);
    check_reset_outputs();
    #3 Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check_eq("idle_mem_en", mem_en, 0);
      check_eq("idle_dec_valid", dec_valid, 0);
    end
    m_pc = 8'h00;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Called at the negedge of a FETCH cycle; returns 1 if a halt was reached.
  task automatic run_instr(input bit force_f, input logic [3:0] fv, input int hold,
                           output bit got_halt);
    logic [31:0] w;
    logic [3:0]  f;
    int unsigned dly, nh;
    got_halt = 1'b0;
    check_eq("fetch_en", mem_en, 1);
    check_eq("fetch_addr", mem_addr, {24'h0, m_pc});
    check_eq("mem_rw", mem_rw, 0);
    f = force_f ? fv : 4'($urandom);
    flags     = f;
    w         = mem[m_pc];
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    dec_ready = 1'($urandom);
    start     = 1'($urandom);
    @(negedge Clk);
    dly = $urandom_range(0, 2);
    mem_ready = 1'b0;
    for (int unsigned i = 0; i < dly; i++) begin
      mem_rdata = $urandom;
      @(negedge Clk);
      check_eq("wait_addr", mem_addr, {24'h0, m_pc});
      check_eq("wait_mem_en", mem_en, 0);
    end
    mem_ready = 1'b1;
    mem_rdata = w;
    @(negedge Clk);
    mem_ready = 1'b0;
    dec_ready = 1'b0;
    start     = 1'b0;
    mem_rdata = $urandom;
    if (cond_pass(w[31:28], f) && w[27:24] == 4'hF) begin
      check_eq("halt_halted", halted, 1);
      check_eq("halt_mem_en", mem_en, 0);
      check_eq("halt_dec_valid", dec_valid, 0);
      got_halt = 1'b1;
    end else if (cond_pass(w[31:28], f)) begin
      check_eq("issue_valid", dec_valid, 1);
      check_eq("issue_fields", {cond, opcode, s, rd, rs2, rs1, iv},
               {w[31:28], w[27:24], w[23], w[22:19], w[18:15], w[14:11], w[10:6]});
      check_eq("issue_pc", pc, m_pc);
      nh = (hold < 0) ? $urandom_range(0, 3) : hold;
      for (int unsigned i = 0; i < nh; i++) begin
        flags = $urandom;
        @(negedge Clk);
        check_eq("stall_valid", dec_valid, 1);
        check_eq("stall_mem_en", mem_en, 0);
        check_eq("stall_fields", {opcode, rd, rs1, iv}, {w[27:24], w[22:19], w[14:11], w[10:6]});
      end
      dec_ready = 1'b1;
      @(negedge Clk);
      dec_ready = 1'b0;
      m_pc = (w[27:24] == 4'hA) ? branch_target(m_pc, w) : m_pc + 8'd1;
    end else begin
      check_eq("skip_valid", dec_valid, 0);
      m_pc = m_pc + 8'd1;
    end
  endtask

  initial begin
    bit hlt;
    logic [31:0] w;
    Reset = 1'b0; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    flags = '0; dec_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h01000000;
    #3 check_reset_outputs();

    // First instruction, long consumer stall, then sequential fetch.
    mem[0] = 32'h06280060;
    mem[1] = 32'h13000040;
    mem[2] = 32'h13000040;
    mem[3] = {4'h0, 4'hA, 5'h00, 19'd13};
    mem[16] = {4'h0, 4'hA, 5'h00, 19'h7FFF0};
    mem[255] = 32'h03123456;
    do_reset();
    run_instr(1'b0, 4'h0, 5, hlt);
    run_instr(1'b1, 4'b0000, -1, hlt);
    run_instr(1'b1, 4'b0100, -1, hlt);
    run_instr(1'b0, 4'h0, -1, hlt);
    run_instr(1'b0, 4'h0, -1, hlt);
    mem[0] = {4'h0, 4'hA, 5'h00, 19'h7FFFF};
    run_instr(1'b0, 4'h0, -1, hlt);
    run_instr(1'b0, 4'h0, -1, hlt);
    check_eq("wrap_pc", {24'h0, m_pc}, 0);

    // Never-condition word: issued unless conditional execution is built in.
    mem[m_pc] = 32'hF2ABCDEF;
    run_instr(1'b0, 4'h0, -1, hlt);

    // Random program with random flags, memory latency and consumer stalls.
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[27:24] == 4'hF) w[27:24] = 4'h0;
      mem[i] = w;
    end
    for (int i = 0; i < 200; i++) run_instr(1'b0, 4'h0, -1, hlt);

    // Halt: no further fetches regardless of start or mem_ready.
    mem[m_pc] = 32'h0F000000;
    run_instr(1'b0, 4'h0, -1, hlt);
    check_eq("halt_reached", {31'h0, hlt}, 1);
    for (int i = 0; i < 8; i++) begin
      start = 1'($urandom); mem_ready = 1'($urandom); dec_ready = 1'($urandom);
      @(negedge Clk);
      check_eq("halt_hold_en", mem_en, 0);
      check_eq("halt_hold", halted, 1);
    end

    // Reset from HALT, then reset in the middle of WAIT.
    mem[0] = 32'h01234567;
    do_reset();
    check_eq("restart_en", mem_en, 1);
    @(negedge Clk);
    check_eq("mid_wait_addr", mem_addr, 0);
    do_reset();

    // Reset in the middle of an ISSUE handshake.
    run_instr(1'b0, 4'h0, -1, hlt);
    mem_ready = 1'b0;
    @(negedge Clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h01ABCDEF;
    @(negedge Clk);
    mem_ready = 1'b0;
    check_eq("pre_rst_valid", dec_valid, 1);
    dec_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) run_instr(1'b0, 4'h0, -1, hlt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
